median_select_ctrl: RTL and testbench

Iterative quickselect sequencer for the median filter's partitioning datapath (`fill_buffers`). It drives the pivot and buffer-size inputs of `fill_buffers`, evaluates the partition sizes and min/max values it reports after each pass, and decides which partition is recirculated next. It produces the median (the k-th smallest pixel of the window) once the target position falls in the equal partition or in a single-valued partition. It sits between the window/recirculation buffers and the partitioner.

---
 rtl/median_pkg.sv | 18 +
 rtl/median_select_ctrl_pivot_mid.sv | 18 +
 rtl/median_select_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_median_select_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types and constants for the median quickselect sequencer.
package median_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_DECIDE,
    ST_DONE
  } state_t;

  localparam logic [1:0] SEL_WIN  = 2'b00;
  localparam logic [1:0] SEL_LOW  = 2'b01;
  localparam logic [1:0] SEL_LARG = 2'b10;

  localparam logic [7:0] PIVOT_INIT = 8'd128;

endpackage

// File: rtl/median_select_ctrl_pivot_mid.sv
// Ceiling midpoint of two 8-bit pixel values: (lo + hi + 1) >> 1 via a 9-bit sum.
module pivot_mid (
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  output logic [7:0] mid
);

  // Rounding up keeps the pivot strictly above the minimum, so a
  // two-valued partition always splits.
  function automatic logic [7:0] ceil_mid(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b} + 9'd1;
    return sum[8:1];
  endfunction

  assign mid = ceil_mid(lo, hi);

endmodule

// File: rtl/median_select_ctrl.sv
// Quickselect sequencer: drives the partitioner pass by pass and narrows the
// target rank until it lands in the equal partition or a single-valued one.
module median_select_ctrl
  import median_pkg::*;
#(
  parameter int BUFF_SIZE     = 32,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter int MAX_PASSES    = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [BUFF_SIZE_BIT-1:0] win_size,
  input  logic [BUFF_SIZE_BIT-1:0] med_pos,
  output logic [7:0]               pivot,
  output logic [BUFF_SIZE_BIT-1:0] buff_size,
  output logic                     send_req,
  output logic [1:0]               sel,
  input  logic                     fill_done,
  input  logic [BUFF_SIZE_BIT-1:0] lower_size,
  input  logic [BUFF_SIZE_BIT-1:0] equal_size,
  input  logic [BUFF_SIZE_BIT-1:0] larger_size,
  input  logic [7:0]               min_lower,
  input  logic [7:0]               max_lower,
  input  logic [7:0]               min_larger,
  input  logic [7:0]               max_larger,
  output logic                     busy,
  output logic [7:0]               median,
  output logic                     median_valid,
  output logic [3:0]               passes,
  output logic                     err
);

  localparam logic [3:0] PASS_LIMIT = 4'(MAX_PASSES);

  state_t                   state_q, state_d;
  logic [BUFF_SIZE_BIT-1:0] k_q, k_d;
  logic [7:0]               pivot_d;
  logic [BUFF_SIZE_BIT-1:0] buff_size_d;
  logic [1:0]               sel_d;
  logic                     send_req_d;
  logic                     busy_d;
  logic [7:0]               median_d;
  logic                     median_valid_d;
  logic [3:0]               passes_d;
  logic                     err_d;

  logic [7:0]               mid_lower, mid_larger;
  logic [BUFF_SIZE_BIT:0]   le_sum;
  logic                     pass_limit;

  pivot_mid u_mid_lower (
    .lo  (min_lower),
    .hi  (max_lower),
    .mid (mid_lower)
  );

  pivot_mid u_mid_larger (
    .lo  (min_larger),
    .hi  (max_larger),
    .mid (mid_larger)
  );

  // One extra bit so L+E never wraps at a full window.
  assign le_sum     = {1'b0, lower_size} + {1'b0, equal_size};
  assign pass_limit = (passes >= PASS_LIMIT);

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    pivot_d        = pivot;
    buff_size_d    = buff_size;
    sel_d          = sel;
    send_req_d     = 1'b0;
    busy_d         = busy;
    median_d       = median;
    median_valid_d = 1'b0;
    passes_d       = passes;
    err_d          = err;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          k_d         = med_pos;
          buff_size_d = win_size;
          pivot_d     = PIVOT_INIT;
          sel_d       = SEL_WIN;
          passes_d    = '0;
          err_d       = 1'b0;
          send_req_d  = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_REQ;
        end
      end

      ST_REQ: begin
        passes_d = passes + 4'd1;
        state_d  = ST_FILL;
      end

      ST_FILL: begin
        if (fill_done) state_d = ST_DECIDE;
      end

      ST_DECIDE: begin
        if (k_q < lower_size) begin
          if (min_lower == max_lower) begin
            median_d       = min_lower;
            median_valid_d = 1'b1;
            state_d        = ST_DONE;
          end else if (pass_limit) begin
            err_d          = 1'b1;
            median_d       = pivot;
            median_valid_d = 1'b1;
            state_d        = ST_DONE;
          end else begin
            buff_size_d = lower_size;
            sel_d       = SEL_LOW;
            pivot_d     = mid_lower;
            send_req_d  = 1'b1;
            state_d     = ST_REQ;
          end
        end else if ({1'b0, k_q} < le_sum) begin
          median_d       = pivot;
          median_valid_d = 1'b1;
          state_d        = ST_DONE;
        end else begin
          // Rank is re-based into the larger partition.
          k_d = k_q - lower_size - equal_size;
          if (min_larger == max_larger) begin
            median_d       = min_larger;
            median_valid_d = 1'b1;
            state_d        = ST_DONE;
          end else if (pass_limit) begin
            err_d          = 1'b1;
            median_d       = pivot;
            median_valid_d = 1'b1;
            state_d        = ST_DONE;
          end else begin
            buff_size_d = larger_size;
            sel_d       = SEL_LARG;
            pivot_d     = mid_larger;
            send_req_d  = 1'b1;
            state_d     = ST_REQ;
          end
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      pivot        <= PIVOT_INIT;
      buff_size    <= '0;
      sel          <= SEL_WIN;
      send_req     <= 1'b0;
      busy         <= 1'b0;
      median       <= '0;
      median_valid <= 1'b0;
      passes       <= '0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      pivot        <= pivot_d;
      buff_size    <= buff_size_d;
      sel          <= sel_d;
      send_req     <= send_req_d;
      busy         <= busy_d;
      median       <= median_d;
      median_valid <= median_valid_d;
      passes       <= passes_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_median_select_ctrl.sv
// Bench for median_select_ctrl with a behavioural partitioner/recirculation model.
module tb_median_select_ctrl;
  import median_pkg::*;

  localparam int BSB = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [BSB-1:0] win_size = '0;
  logic [BSB-1:0] med_pos = '0;
  logic [7:0]     pivot;
  logic [BSB-1:0] buff_size;
  logic           send_req;
  logic [1:0]     sel;
  logic           fill_done = 1'b0;
  logic [BSB-1:0] lower_size = '0, equal_size = '0, larger_size = '0;
  logic [7:0]     min_lower = '0, max_lower = '0, min_larger = '0, max_larger = '0;
  logic           busy;
  logic [7:0]     median;
  logic           median_valid;
  logic [3:0]     passes;
  logic           err;

  median_select_ctrl #(.BUFF_SIZE(32), .BUFF_SIZE_BIT(BSB), .MAX_PASSES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_size(win_size), .med_pos(med_pos),
    .pivot(pivot), .buff_size(buff_size), .send_req(send_req), .sel(sel),
    .fill_done(fill_done), .lower_size(lower_size), .equal_size(equal_size),
    .larger_size(larger_size), .min_lower(min_lower), .max_lower(max_lower),
    .min_larger(min_larger), .max_larger(max_larger), .busy(busy), .median(median),
    .median_valid(median_valid), .passes(passes), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int size_mism = 0;
  bit stuck = 1'b0;
  logic [7:0] win_q[$], low_q[$], larg_q[$];

  // Partitioner + recirculation: splits the selected set around pivot,
  // takes one cycle per pixel, then pulses fill_done.
  always @(negedge clk) begin
    if (rst_n && send_req === 1'b1) begin : part
      logic [7:0] src[$], nl[$], ne[$], ng[$];
      bit aborted;
      int n;
      if (sel == SEL_LOW) src = low_q;
      else if (sel == SEL_LARG) src = larg_q;
      else src = win_q;
      if (int'(buff_size) != src.size()) size_mism++;
      nl = {}; ne = {}; ng = {};
      foreach (src[i]) begin
        if (src[i] < pivot) nl.push_back(src[i]);
        else if (src[i] == pivot) ne.push_back(src[i]);
        else ng.push_back(src[i]);
      end
      if (stuck) begin nl = src; ne = {}; ng = {}; end
      n = (src.size() > 0) ? src.size() : 1;
      aborted = 1'b0;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        if (!rst_n) begin aborted = 1'b1; break; end
      end
      if (!aborted) begin
        lower_size  = BSB'(nl.size());
        equal_size  = BSB'(ne.size());
        larger_size = BSB'(ng.size());
        min_lower = 8'hff; max_lower = 8'h00; min_larger = 8'hff; max_larger = 8'h00;
        foreach (nl[i]) begin
          if (nl[i] < min_lower) min_lower = nl[i];
          if (nl[i] > max_lower) max_lower = nl[i];
        end
        foreach (ng[i]) begin
          if (ng[i] < min_larger) min_larger = ng[i];
          if (ng[i] > max_larger) max_larger = ng[i];
        end
        if (stuck) begin min_lower = 8'd0; max_lower = 8'd255; end
        low_q = nl;
        larg_q = ng;
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
      end
    end
  end

  function automatic logic [7:0] ref_median(input int k);
    logic [7:0] s[$];
    s = win_q;
    s.sort();
    return s[k];
  endfunction

  task automatic run_sel(input int k, output logic [7:0] med, output logic [3:0] np,
                         output logic er, output int cyc, output bit tmo);
    @(negedge clk);
    start = 1'b1;
    win_size = BSB'(win_q.size());
    med_pos = BSB'(k);
    @(negedge clk);
    start = 1'b0;
    tmo = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (median_valid === 1'b1) begin cyc = c; tmo = 1'b0; break; end
    end
    med = median; np = passes; er = err;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (pivot !== 8'd128) begin bad++; $display("FAIL reset_pivot: got %0d expected 128", pivot); end
    total++; if (buff_size !== '0 || sel !== 2'b00) begin bad++; $display("FAIL reset_size_sel: got %0d/%0d expected 0/0", buff_size, sel); end
    total++; if ({send_req, busy, median_valid, err} !== 4'b0) begin bad++; $display("FAIL reset_ctrl: got %b expected 0000", {send_req, busy, median_valid, err}); end
    total++; if (median !== 8'd0 || passes !== 4'd0) begin bad++; $display("FAIL reset_data: got %0d/%0d expected 0/0", median, passes); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_equal;
    logic [7:0] med; logic [3:0] np; logic er; int cyc; bit tmo;
    win_q = {};
    repeat (9) win_q.push_back(8'd5);
    run_sel(4, med, np, er, cyc, tmo);
    total++; if (tmo) begin bad++; $display("FAIL eq_timeout: got timeout expected median_valid"); end
    total++; if (med !== 8'd5) begin bad++; $display("FAIL eq_median: got %0d expected 5", med); end
    total++; if (np !== 4'd1) begin bad++; $display("FAIL eq_passes: got %0d expected 1", np); end
    total++; if (cyc != 11) begin bad++; $display("FAIL eq_latency: got %0d expected 11", cyc); end
    @(negedge clk);
    total++; if (median_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL eq_pulse_end: got mv=%b busy=%b expected 0 0", median_valid, busy); end
  endtask

  task automatic test_ramp;
    logic [7:0] med; logic [3:0] np; logic er; int cyc; bit tmo;
    win_q = {};
    for (int i = 1; i <= 9; i++) win_q.push_back(8'(i));
    run_sel(4, med, np, er, cyc, tmo);
    total++; if (tmo || med !== 8'd5) begin bad++; $display("FAIL ramp_median: got %0d (tmo=%0d) expected 5", med, tmo); end
    total++; if (np !== 4'd2) begin bad++; $display("FAIL ramp_passes: got %0d expected 2", np); end
  endtask

  task automatic test_larger_branch;
    logic [7:0] med; logic [3:0] np; logic er; int cyc; bit tmo;
    win_q = {8'd200, 8'd201, 8'd202};
    run_sel(1, med, np, er, cyc, tmo);
    total++; if (tmo || med !== 8'd201) begin bad++; $display("FAIL larg_median: got %0d (tmo=%0d) expected 201", med, tmo); end
    total++; if (np !== 4'd2) begin bad++; $display("FAIL larg_passes: got %0d expected 2", np); end
  endtask

  task automatic test_extremes;
    logic [7:0] med; logic [3:0] np; logic er; int cyc; bit tmo;
    win_q = {};
    for (int i = 0; i < 16; i++) begin win_q.push_back(8'd0); win_q.push_back(8'd255); end
    run_sel(16, med, np, er, cyc, tmo);
    total++; if (tmo || med !== 8'd255) begin bad++; $display("FAIL ext_median: got %0d (tmo=%0d) expected 255", med, tmo); end
    total++; if (np !== 4'd1 || er !== 1'b0) begin bad++; $display("FAIL ext_passes_err: got %0d/%0d expected 1/0", np, er); end
  endtask

  task automatic test_random;
    logic [7:0] med, exp_med; logic [3:0] np; logic er; int cyc; bit tmo;
    int n, k, base, v;
    for (int it = 0; it < 25; it++) begin
      win_q = {};
      n = $urandom_range(1, 32);
      base = $urandom_range(0, 255);
      for (int i = 0; i < n; i++) begin
        if (it % 3 == 0) begin
          v = base + $urandom_range(0, 3);
          if (v > 255) v = 255;
        end else v = $urandom_range(0, 255);
        win_q.push_back(8'(v));
      end
      k = $urandom_range(0, n - 1);
      exp_med = ref_median(k);
      run_sel(k, med, np, er, cyc, tmo);
      total++;
      if (tmo || med !== exp_med || er !== 1'b0 || np > 4'd10) begin
        bad++;
        $display("FAIL rand_%0d: got med=%0d err=%0d passes=%0d tmo=%0d expected med=%0d err=0 (n=%0d k=%0d)",
                 it, med, er, np, tmo, exp_med, n, k);
      end
    end
    total++; if (size_mism != 0) begin bad++; $display("FAIL buff_size_track: got %0d mismatches expected 0", size_mism); end
  endtask

  task automatic test_start_busy;
    logic [7:0] exp_med;
    bit tmo;
    win_q = {};
    for (int i = 0; i < 7; i++) win_q.push_back(8'($urandom_range(0, 255)));
    exp_med = ref_median(3);
    @(negedge clk);
    start = 1'b1; win_size = BSB'(7); med_pos = BSB'(3);
    @(negedge clk);
    start = 1'b0;
    total++; if (send_req !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL start_to_req: got req=%b busy=%b expected 1 1", send_req, busy); end
    @(negedge clk);
    total++; if (send_req !== 1'b0) begin bad++; $display("FAIL req_one_cycle: got %b expected 0", send_req); end
    start = 1'b1; med_pos = BSB'(0);
    @(negedge clk);
    start = 1'b0;
    tmo = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (median_valid === 1'b1) begin tmo = 1'b0; break; end
    end
    total++; if (tmo || median !== exp_med) begin bad++; $display("FAIL start_ignored: got %0d (tmo=%0d) expected %0d", median, tmo, exp_med); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] med, exp_med; logic [3:0] np; logic er; int cyc; bit tmo;
    win_q = {};
    for (int i = 0; i < 20; i++) win_q.push_back(8'($urandom_range(0, 255)));
    @(negedge clk);
    start = 1'b1; win_size = BSB'(20); med_pos = BSB'(10);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || send_req !== 1'b0) begin bad++; $display("FAIL async_reset: got busy=%b req=%b expected 0 0", busy, send_req); end
    total++; if (passes !== 4'd0 || pivot !== 8'd128) begin bad++; $display("FAIL async_reset_data: got passes=%0d pivot=%0d expected 0 128", passes, pivot); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    win_q = {};
    for (int i = 0; i < 11; i++) win_q.push_back(8'($urandom_range(0, 255)));
    exp_med = ref_median(5);
    run_sel(5, med, np, er, cyc, tmo);
    total++; if (tmo || med !== exp_med) begin bad++; $display("FAIL after_reset: got %0d (tmo=%0d) expected %0d", med, tmo, exp_med); end
  endtask

  task automatic test_pass_limit;
    logic [7:0] med, exp_med; logic [3:0] np; logic er; int cyc; bit tmo;
    win_q = {8'd3, 8'd9, 8'd40, 8'd77};
    stuck = 1'b1;
    run_sel(1, med, np, er, cyc, tmo);
    stuck = 1'b0;
    total++; if (tmo) begin bad++; $display("FAIL limit_timeout: got timeout expected median_valid"); end
    total++; if (er !== 1'b1 || np !== 4'd10) begin bad++; $display("FAIL limit_err: got err=%0d passes=%0d expected 1 10", er, np); end
    total++; if (med !== 8'd128) begin bad++; $display("FAIL limit_median: got %0d expected 128", med); end
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0d expected 1", err); end
    exp_med = ref_median(2);
    run_sel(2, med, np, er, cyc, tmo);
    total++; if (tmo || er !== 1'b0 || med !== exp_med) begin bad++; $display("FAIL err_clear: got err=%0d med=%0d expected 0 %0d", er, med, exp_med); end
  endtask

  initial begin
    test_reset();
    test_all_equal();
    test_ramp();
    test_larger_branch();
    test_extremes();
    test_random();
    test_start_busy();
    test_reset_mid();
    test_pass_limit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
